// File: rtl/coin_sprite_arbiter.sv
// Round-robin arbiter sharing one coin sprite ROM among NUM_REQ pixel requesters,
// with a frame-tick animation sequencer. Define COIN_ARB_PINGPONG_EN for 0-1-2-3-2-1 ping-pong frames.
module coin_sprite_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = 8,
  parameter int SPR_DIM     = 20
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 anim_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] req_col,
  input  logic [NUM_REQ*5-1:0] req_row,
  output logic [NUM_REQ-1:0]   grant,
  output logic [8:0]           rom_addr,
  output logic [1:0]           rom_frame,
  input  logic [23:0]          rom_color,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [23:0]          rsp_color,
  output logic                 rsp_transparent
);

  localparam logic [23:0] KEY_COLOR = 24'h800080;
  localparam logic [5:0]  DIM6      = 6'(SPR_DIM);
  localparam logic [7:0]  TC_LAST   = 8'(FRAME_TICKS - 1);
  localparam logic [2:0]  ID_LAST   = 3'(NUM_REQ - 1);

  logic [2:0] ptr;
  logic [2:0] gnt_id;
  logic       gnt_any;
  logic [4:0] gnt_col;
  logic [4:0] gnt_row;
  logic       oor;
  logic [8:0] addr_full;
  logic [7:0] tcnt, tcnt_nxt;
  logic [1:0] frame, frame_nxt;

  // Two passes: first asserted req at or above ptr, otherwise wrap to the lowest one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req[i] && (i >= int'(ptr))) begin
        gnt_any = 1'b1;
        gnt_id  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_any = 1'b1;
        gnt_id  = 3'(i);
      end
    end
  end

  always_comb begin
    grant   = '0;
    gnt_col = '0;
    gnt_row = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_id == 3'(i))) begin
        grant[i] = 1'b1;
        gnt_col  = req_col[5*i +: 5];
        gnt_row  = req_row[5*i +: 5];
      end
    end
  end

  assign oor       = ({1'b0, gnt_col} >= DIM6) || ({1'b0, gnt_row} >= DIM6);
  assign addr_full = 9'(gnt_row) * 9'(SPR_DIM) + 9'(gnt_col);
  assign rom_addr  = (gnt_any && !oor) ? addr_full : '0;
  assign rom_frame = frame;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr             <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_color       <= '0;
      rsp_transparent <= 1'b0;
    end else begin
      rsp_valid <= gnt_any;
      if (gnt_any) begin
        ptr             <= (gnt_id == ID_LAST) ? 3'd0 : gnt_id + 3'd1;
        rsp_id          <= gnt_id;
        rsp_color       <= oor ? 24'h0 : rom_color;
        rsp_transparent <= oor || (rom_color == KEY_COLOR);
      end
    end
  end

`ifdef COIN_ARB_PINGPONG_EN
  logic dir_down, dir_down_nxt;

  always_comb begin
    tcnt_nxt     = tcnt;
    frame_nxt    = frame;
    dir_down_nxt = dir_down;
    if (frame_tick && anim_en) begin
      if (tcnt == TC_LAST) begin
        tcnt_nxt = '0;
        if (!dir_down) begin
          if (frame == 2'd3) begin
            frame_nxt    = 2'd2;
            dir_down_nxt = 1'b1;
          end else begin
            frame_nxt = frame + 2'd1;
          end
        end else begin
          if (frame == 2'd0) begin
            frame_nxt    = 2'd1;
            dir_down_nxt = 1'b0;
          end else begin
            frame_nxt = frame - 2'd1;
          end
        end
      end else begin
        tcnt_nxt = tcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt     <= '0;
      frame    <= '0;
      dir_down <= 1'b0;
    end else begin
      tcnt     <= tcnt_nxt;
      frame    <= frame_nxt;
      dir_down <= dir_down_nxt;
    end
  end
`else
  always_comb begin
    tcnt_nxt  = tcnt;
    frame_nxt = frame;
    if (frame_tick && anim_en) begin
      if (tcnt == TC_LAST) begin
        tcnt_nxt  = '0;
        frame_nxt = frame + 2'd1;
      end else begin
        tcnt_nxt = tcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt  <= '0;
      frame <= '0;
    end else begin
      tcnt  <= tcnt_nxt;
      frame <= frame_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_coin_sprite_arbiter.sv
// Self-checking bench for coin_sprite_arbiter: vector table for arbitration and addressing,
// hand sequences for the frame sequencer and reset during an in-flight lookup.
module tb_coin_sprite_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        frame_tick;
  logic        anim_en;
  logic [3:0]  req;
  logic [19:0] req_col;
  logic [19:0] req_row;
  logic [3:0]  grant;
  logic [8:0]  rom_addr;
  logic [1:0]  rom_frame;
  logic [23:0] rom_color;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [23:0] rsp_color;
  logic        rsp_transparent;

  logic        model_en;
  logic [23:0] drv_color;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic [19:0] col;
    logic [19:0] row;
    logic [23:0] color;
    logic [3:0]  gnt;
    logic [8:0]  addr;
    logic        v;
    logic [2:0]  id;
    logic [23:0] rcol;
    logic        tr;
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    logic [23:0] col;
    logic        tr;
  } rsp_t;

  vec_t tbl[14];
  rsp_t sb[$];
  logic [1:0] exp_fr[12];

  coin_sprite_arbiter #(
    .NUM_REQ(4),
    .FRAME_TICKS(2),
    .SPR_DIM(20)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .anim_en(anim_en),
    .req(req),
    .req_col(req_col),
    .req_row(req_row),
    .grant(grant),
    .rom_addr(rom_addr),
    .rom_frame(rom_frame),
    .rom_color(rom_color),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_color(rsp_color),
    .rsp_transparent(rsp_transparent)
  );

  // ROM stand-in: colour encodes frame and address so frame mixing is visible.
  function automatic logic [23:0] model(input logic [1:0] f, input logic [8:0] a);
    return {6'd0, f, 7'd0, a};
  endfunction

  assign rom_color = model_en ? model(rom_frame, rom_addr) : drv_color;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [19:0] pk(input logic [4:0] a0, input logic [4:0] a1,
                                     input logic [4:0] a2, input logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input string nm);
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " rsp_id"}, 32'(rsp_id), 32'(e.id));
      chk({nm, " rsp_color"}, 32'(rsp_color), 32'(e.col));
      chk({nm, " rsp_transparent"}, 32'(rsp_transparent), 32'(e.tr));
    end else begin
      chk({nm, " rsp_valid idle"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic run_cycle(input string nm, input logic [3:0] r, input logic [19:0] c,
                           input logic [19:0] rw, input logic ft, input logic [23:0] color,
                           input logic [3:0] exp_gnt, input logic [8:0] exp_addr,
                           input logic exp_v, input logic [2:0] exp_id,
                           input logic [23:0] exp_col, input logic exp_tr);
    rsp_t e;
    @(negedge Clk);
    req        = r;
    req_col    = c;
    req_row    = rw;
    frame_tick = ft;
    drv_color  = color;
    #2;
    chk({nm, " grant"}, 32'(grant), 32'(exp_gnt));
    chk({nm, " rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    if (exp_v) begin
      e.id  = exp_id;
      e.col = exp_col;
      e.tr  = exp_tr;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    check_rsp(nm);
  endtask

  task automatic do_reset();
    Reset_n    = 1'b0;
    req        = '0;
    req_col    = '0;
    req_row    = '0;
    frame_tick = 1'b0;
    drv_color  = '0;
    sb.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    model_en = 1'b0;
    anim_en  = 1'b1;
    do_reset();

    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rom_frame", 32'(rom_frame), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset rsp_color", 32'(rsp_color), 32'd0);

    for (int i = 0; i < 5; i++)
      tbl[i] = '{4'b1111, 20'd0, 20'd0, 24'h000010 + 24'(i), 4'(1 << (i % 4)), 9'd0,
                 1'b1, 3'(i % 4), 24'h000010 + 24'(i), 1'b0};
    tbl[5]  = '{4'b0100, pk(0, 0, 5, 0), pk(0, 0, 3, 0), 24'h123456, 4'b0100, 9'd65,
                1'b1, 3'd2, 24'h123456, 1'b0};
    tbl[6]  = '{4'b0100, pk(0, 0, 20, 0), 20'd0, 24'hABCDEF, 4'b0100, 9'd0,
                1'b1, 3'd2, 24'h000000, 1'b1};
    tbl[7]  = '{4'b0001, 20'd0, 20'd0, 24'h800080, 4'b0001, 9'd0,
                1'b1, 3'd0, 24'h800080, 1'b1};
    tbl[8]  = '{4'b0000, 20'd0, 20'd0, 24'h111111, 4'b0000, 9'd0,
                1'b0, 3'd0, 24'h0, 1'b0};
    tbl[9]  = '{4'b1001, pk(1, 0, 0, 19), pk(1, 0, 0, 19), 24'h00AA00, 4'b1000, 9'd399,
                1'b1, 3'd3, 24'h00AA00, 1'b0};
    tbl[10] = '{4'b1001, pk(1, 0, 0, 19), pk(1, 0, 0, 19), 24'h00BB00, 4'b0001, 9'd21,
                1'b1, 3'd0, 24'h00BB00, 1'b0};
    tbl[11] = '{4'b0011, pk(1, 0, 0, 19), pk(1, 19, 0, 19), 24'h00CC00, 4'b0010, 9'd380,
                1'b1, 3'd1, 24'h00CC00, 1'b0};
    tbl[12] = '{4'b0011, pk(1, 0, 0, 19), pk(1, 19, 0, 19), 24'h00DD00, 4'b0001, 9'd21,
                1'b1, 3'd0, 24'h00DD00, 1'b0};
    tbl[13] = '{4'b0001, 20'd0, pk(20, 0, 0, 0), 24'h0000FF, 4'b0001, 9'd0,
                1'b1, 3'd0, 24'h000000, 1'b1};

    for (int i = 0; i < 14; i++)
      run_cycle($sformatf("vec%0d", i), tbl[i].req, tbl[i].col, tbl[i].row, 1'b0,
                tbl[i].color, tbl[i].gnt, tbl[i].addr, tbl[i].v, tbl[i].id,
                tbl[i].rcol, tbl[i].tr);
    run_cycle("drain", 4'b0, 20'd0, 20'd0, 1'b0, 24'h0, 4'b0, 9'd0, 1'b0, 3'd0, 24'h0, 1'b0);

`ifdef COIN_ARB_PINGPONG_EN
    exp_fr = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
`else
    exp_fr = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
`endif

    // Each tick coincides with a lookup; its response must use the pre-tick frame.
    do_reset();
    model_en = 1'b1;
    anim_en  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("tick%0d rom_frame", k), 32'(rom_frame), 32'(exp_fr[k]));
      run_cycle($sformatf("tick%0d", k), 4'b0010, pk(0, 2, 0, 0), pk(0, 1, 0, 0), 1'b1,
                24'h0, 4'b0010, 9'd22, 1'b1, 3'd1, model(exp_fr[k], 9'd22), 1'b0);
      run_cycle($sformatf("gap%0d", k), 4'b0, 20'd0, 20'd0, 1'b0, 24'h0, 4'b0, 9'd0,
                1'b0, 3'd0, 24'h0, 1'b0);
    end
`ifdef COIN_ARB_PINGPONG_EN
    chk("after 12 ticks rom_frame", 32'(rom_frame), 32'd0);
`else
    chk("after 12 ticks rom_frame", 32'(rom_frame), 32'd2);
`endif

    anim_en = 1'b0;
    for (int k = 0; k < 3; k++)
      run_cycle("frozen tick", 4'b0, 20'd0, 20'd0, 1'b1, 24'h0, 4'b0, 9'd0,
                1'b0, 3'd0, 24'h0, 1'b0);
`ifdef COIN_ARB_PINGPONG_EN
    chk("frozen rom_frame", 32'(rom_frame), 32'd0);
`else
    chk("frozen rom_frame", 32'(rom_frame), 32'd2);
`endif
    anim_en = 1'b1;
    run_cycle("resume tick a", 4'b0, 20'd0, 20'd0, 1'b1, 24'h0, 4'b0, 9'd0,
              1'b0, 3'd0, 24'h0, 1'b0);
`ifdef COIN_ARB_PINGPONG_EN
    chk("resume a rom_frame", 32'(rom_frame), 32'd0);
`else
    chk("resume a rom_frame", 32'(rom_frame), 32'd2);
`endif
    run_cycle("resume tick b", 4'b0, 20'd0, 20'd0, 1'b1, 24'h0, 4'b0, 9'd0,
              1'b0, 3'd0, 24'h0, 1'b0);
`ifdef COIN_ARB_PINGPONG_EN
    chk("resume b rom_frame", 32'(rom_frame), 32'd1);
`else
    chk("resume b rom_frame", 32'(rom_frame), 32'd3);
`endif

    // Reset lands while a grant is in flight with frame 2 showing.
    model_en = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++)
      run_cycle("pre tick", 4'b0, 20'd0, 20'd0, 1'b1, 24'h0, 4'b0, 9'd0,
                1'b0, 3'd0, 24'h0, 1'b0);
    @(negedge Clk);
    req        = 4'b1100;
    req_col    = '0;
    req_row    = '0;
    frame_tick = 1'b0;
    drv_color  = 24'h00EE00;
    #2;
    chk("inflight grant", 32'(grant), 32'b0100);
    chk("inflight rom_frame", 32'(rom_frame), 32'd2);
    #1 Reset_n = 1'b0;
    #1;
    chk("async rst rom_frame", 32'(rom_frame), 32'd0);
    chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst edge rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    req     = 4'b0110;
    #2;
    chk("post rst grant", 32'(grant), 32'b0010);
    sb.push_back('{3'd1, 24'h00EE00, 1'b0});
    @(posedge Clk);
    #1;
    check_rsp("post rst");
    run_cycle("final idle", 4'b0, 20'd0, 20'd0, 1'b0, 24'h0, 4'b0, 9'd0,
              1'b0, 3'd0, 24'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
